scarf_sram_arbiter: RTL

- Owns the single on-board async SRAM port and time-shares it between three requesters:
  - the pattern generator (read-only, streaming);
  - the trigger capture block (write-only);
  - the SCARF host path (read/write).
- Generates ce_n/oe_n/we_n strobes with a configurable wait-state count and returns read data with a valid pulse.
- Sits between the SCARF slave blocks and the SRAM pins, replacing per-block address muxing.

---
 rtl/scarf_sram_pkg.sv | 19 +
 rtl/sram_rr_arb.sv | 56 +++++
 rtl/scarf_sram_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/scarf_sram_pkg.sv
// Shared types and defaults for the SCARF SRAM arbiter.
package scarf_sram_pkg;

    localparam int ADDR_W_DEF = 19;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } state_t;

    typedef enum logic [1:0] {
        OWN_PG,
        OWN_CAP,
        OWN_HOST
    } owner_t;

endpackage

// File: rtl/sram_rr_arb.sv
// Requester picker: pattern generator has absolute priority, capture and host
// share the remaining slots round-robin. Winner vector bit order is {host, cap, pg}.
module sram_rr_arb
    import scarf_sram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       pg_lock_i,
    input  logic       pg_req_i,
    input  logic       cap_req_i,
    input  logic       host_req_i,
    output logic [2:0] win_o,
    output logic       valid_o
);

    owner_t rr_last_q;
    owner_t rr_last_d;

    always_comb begin
        win_o     = 3'b000;
        rr_last_d = rr_last_q;
        if (pg_req_i) begin
            win_o[0] = 1'b1;
        end else if (!pg_lock_i) begin
            if (cap_req_i && host_req_i) begin
                // Tie goes to whichever of cap/host did not win last time
                if (rr_last_q == OWN_HOST) begin
                    win_o[1] = 1'b1;
                end else begin
                    win_o[2] = 1'b1;
                end
            end else if (cap_req_i) begin
                win_o[1] = 1'b1;
            end else if (host_req_i) begin
                win_o[2] = 1'b1;
            end
        end
        valid_o = |win_o;
        if (en_i && win_o[1]) begin
            rr_last_d = OWN_CAP;
        end
        if (en_i && win_o[2]) begin
            rr_last_d = OWN_HOST;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= OWN_HOST;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/scarf_sram_arbiter.sv
// Time-shares the single async SRAM port between pattern generator, capture
// and SCARF host; all pin-facing signals come straight from flops.
module scarf_sram_arbiter
    import scarf_sram_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pg_lock_i,
    input  logic              pg_req_i,
    input  logic [ADDR_W-1:0] pg_addr_i,
    output logic              pg_gnt_o,
    output logic              pg_rvalid_o,
    input  logic              cap_req_i,
    input  logic [ADDR_W-1:0] cap_addr_i,
    input  logic [7:0]        cap_wdata_i,
    output logic              cap_gnt_o,
    input  logic              host_req_i,
    input  logic              host_rnw_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [7:0]        host_wdata_i,
    output logic              host_gnt_o,
    output logic              host_rvalid_o,
    output logic [7:0]        rdata_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [7:0]        sram_dq_out_o,
    output logic              sram_dq_oe_o,
    input  logic [7:0]        sram_dq_in_i,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o
);

    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("scarf_sram_arbiter: WAIT_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    owner_t            own_q, own_d;
    logic              rnw_q, rnw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic              pg_rvalid_q, pg_rvalid_d;
    logic              host_rvalid_q, host_rvalid_d;

    logic [2:0]        win;
    logic              win_valid;
    logic              in_idle;

    assign in_idle = (state_q == IDLE);

    sram_rr_arb u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (in_idle),
        .pg_lock_i  (pg_lock_i),
        .pg_req_i   (pg_req_i),
        .cap_req_i  (cap_req_i),
        .host_req_i (host_req_i),
        .win_o      (win),
        .valid_o    (win_valid)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        own_d         = own_q;
        rnw_d         = rnw_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        pg_rvalid_d   = 1'b0;
        host_rvalid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = SETUP;
                    if (win[0]) begin
                        own_d  = OWN_PG;
                        rnw_d  = 1'b1;
                        addr_d = pg_addr_i;
                    end else if (win[1]) begin
                        own_d   = OWN_CAP;
                        rnw_d   = 1'b0;
                        addr_d  = cap_addr_i;
                        wdata_d = cap_wdata_i;
                    end else begin
                        own_d   = OWN_HOST;
                        rnw_d   = host_rnw_i;
                        addr_d  = host_addr_i;
                        wdata_d = host_wdata_i;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = CNT_LOAD;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                    // Capture while oe_n is still low; rvalid follows in HOLD
                    if (rnw_q) begin
                        rdata_d       = sram_dq_in_i;
                        pg_rvalid_d   = (own_q == OWN_PG);
                        host_rvalid_d = (own_q == OWN_HOST);
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are decoded from the next state so the pins change on the edge
        ce_n_d  = (state_d == IDLE);
        oe_n_d  = !((state_d == ACCESS) && rnw_d);
        we_n_d  = !((state_d == ACCESS) && !rnw_d);
        dq_oe_d = (state_d != IDLE) && !rnw_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            own_q         <= OWN_HOST;
            rnw_q         <= 1'b1;
            addr_q        <= '0;
            wdata_q       <= 8'h00;
            rdata_q       <= 8'h00;
            ce_n_q        <= 1'b1;
            oe_n_q        <= 1'b1;
            we_n_q        <= 1'b1;
            dq_oe_q       <= 1'b0;
            pg_rvalid_q   <= 1'b0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            own_q         <= own_d;
            rnw_q         <= rnw_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            ce_n_q        <= ce_n_d;
            oe_n_q        <= oe_n_d;
            we_n_q        <= we_n_d;
            dq_oe_q       <= dq_oe_d;
            pg_rvalid_q   <= pg_rvalid_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    assign pg_gnt_o      = in_idle & win[0];
    assign cap_gnt_o     = in_idle & win[1];
    assign host_gnt_o    = in_idle & win[2];
    assign pg_rvalid_o   = pg_rvalid_q;
    assign host_rvalid_o = host_rvalid_q;
    assign rdata_o       = rdata_q;
    assign busy_o        = !in_idle;
    assign sram_addr_o   = addr_q;
    assign sram_dq_out_o = wdata_q;
    assign sram_dq_oe_o  = dq_oe_q;
    assign sram_ce_n_o   = ce_n_q;
    assign sram_oe_n_o   = oe_n_q;
    assign sram_we_n_o   = we_n_q;

endmodule
